// File: rtl/oc8051_fetch_queue_pkg.sv
// Shared types and the 8051 opcode length map for the fetch stage.
package oc8051_fetch_queue_pkg;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_DATA  = 2'd1,
        S_OUT   = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    // Instruction length in bytes (1..3) from the opcode; reserved A5 sizes as 1.
    function automatic logic [1:0] oc8051_instr_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] len;
        hi  = op[7:4];
        lo  = op[3:0];
        len = 2'd1;
        if (lo == 4'h1) begin
            // AJMP / ACALL with an 11-bit target in every row
            len = 2'd2;
        end else if (lo >= 4'h6) begin
            // @Ri and Rn columns: only a few rows carry an operand byte
            case (hi)
                4'h7, 4'h8, 4'hA: len = 2'd2;
                4'hB:             len = 2'd3;
                4'hD:             len = lo[3] ? 2'd2 : 2'd1;
                default:          len = 2'd1;
            endcase
        end else begin
            case (op)
                8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
                8'h75, 8'h85, 8'h90, 8'hB4, 8'hB5, 8'hD5:
                    len = 2'd3;
                8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
                8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
                8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h80, 8'h82, 8'h92,
                8'h94, 8'h95, 8'hA0, 8'hA2, 8'hB0, 8'hB2, 8'hC0, 8'hC2,
                8'hC5, 8'hD0, 8'hD2, 8'hE5, 8'hF5:
                    len = 2'd2;
                default:
                    len = 2'd1;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/oc8051_len_dec.sv
// Combinational opcode-to-length lookup covering all 256 opcodes.
module oc8051_len_dec
    import oc8051_fetch_queue_pkg::*;
(
    input  logic [7:0] op,
    output logic [1:0] len
);

    always_comb begin
        len = oc8051_instr_len(op);
    end

endmodule

// File: rtl/oc8051_fetch_queue.sv
// Fetch stage between the internal program ROM and the decoder: owns the PC, sizes each
// instruction from its opcode and presents it on a valid/ready handshake.
module oc8051_fetch_queue
    import oc8051_fetch_queue_pkg::*;
#(
    parameter logic [15:0] RST_VECTOR  = 16'h0000,
    parameter bit          MASK_UNUSED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    input  logic        rom_ea_int,
    input  logic        jmp_valid,
    input  logic [15:0] jmp_addr,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [7:0]  dec_op1,
    output logic [7:0]  dec_op2,
    output logic [7:0]  dec_op3,
    output logic [15:0] dec_pc,
    output logic [1:0]  dec_len,
    output logic        ext_fault
);

    fetch_state_e state_q, state_d;

    logic [15:0] pc_q;
    logic [15:0] pc_next;
    logic        ea_q;
    logic        dec_valid_q;
    logic [7:0]  dec_op1_q;
    logic [7:0]  dec_op2_q;
    logic [7:0]  dec_op3_q;
    logic [15:0] dec_pc_q;
    logic [1:0]  dec_len_q;
    logic        ext_fault_q;

    logic [1:0]  op_len;
    logic [7:0]  op2_m;
    logic [7:0]  op3_m;
    logic        accept;
    logic        load_instr;
    logic        raise_fault;
    logic        sample_ea;

    oc8051_len_dec u_len_dec (
        .op  (rom_data1),
        .len (op_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // A jump overrides every state, including an accept in the same cycle.
    always_comb begin
        state_d = state_q;
        if (jmp_valid) begin
            state_d = S_DATA;
        end else begin
            unique case (state_q)
                S_ISSUE: state_d = S_DATA;
                S_DATA:  state_d = ea_q ? S_OUT : S_FAULT;
                S_OUT:   state_d = dec_ready ? S_DATA : S_OUT;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_ISSUE;
            endcase
        end
    end

    always_comb begin
        accept      = !jmp_valid && (state_q == S_OUT) && dec_ready;
        load_instr  = !jmp_valid && (state_q == S_DATA) && ea_q;
        raise_fault = !jmp_valid && (state_q == S_DATA) && !ea_q;
        sample_ea   = jmp_valid || accept || (state_q == S_ISSUE);
        pc_next     = pc_q + {14'd0, dec_len_q};
        if (jmp_valid) begin
            rom_addr = jmp_addr;
        end else if (accept) begin
            rom_addr = pc_next;
        end else begin
            rom_addr = pc_q;
        end
    end

    always_comb begin
        op2_m = rom_data2;
        op3_m = rom_data3;
        if (MASK_UNUSED) begin
            if (op_len < 2'd2) begin
                op2_m = 8'h00;
            end
            if (op_len != 2'd3) begin
                op3_m = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RST_VECTOR;
            ea_q        <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_op1_q   <= 8'h00;
            dec_op2_q   <= 8'h00;
            dec_op3_q   <= 8'h00;
            dec_pc_q    <= 16'h0000;
            dec_len_q   <= 2'd0;
            ext_fault_q <= 1'b0;
        end else begin
            if (sample_ea) begin
                ea_q <= rom_ea_int;
            end

            if (jmp_valid) begin
                pc_q <= jmp_addr;
            end else if (accept) begin
                pc_q <= pc_next;
            end

            if (load_instr) begin
                dec_valid_q <= 1'b1;
                dec_op1_q   <= rom_data1;
                dec_op2_q   <= op2_m;
                dec_op3_q   <= op3_m;
                dec_pc_q    <= pc_q;
                dec_len_q   <= op_len;
            end else if (jmp_valid || accept) begin
                dec_valid_q <= 1'b0;
            end

            if (jmp_valid) begin
                ext_fault_q <= 1'b0;
            end else if (raise_fault) begin
                ext_fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        dec_valid = dec_valid_q;
        dec_op1   = dec_op1_q;
        dec_op2   = dec_op2_q;
        dec_op3   = dec_op3_q;
        dec_pc    = dec_pc_q;
        dec_len   = dec_len_q;
        ext_fault = ext_fault_q;
    end

endmodule

// File: tb/tb_oc8051_fetch_queue.sv
// Bench for oc8051_fetch_queue: directed sequences, an opcode vector table and a random run
// checked against a transaction-level model of the fetch stream.
module tb_oc8051_fetch_queue;

    logic        clk;
    logic        rst;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data1;
    logic [7:0]  rom_data2;
    logic [7:0]  rom_data3;
    logic        rom_ea_int;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        dec_ready;
    logic        dec_valid;
    logic [7:0]  dec_op1;
    logic [7:0]  dec_op2;
    logic [7:0]  dec_op3;
    logic [15:0] dec_pc;
    logic [1:0]  dec_len;
    logic        ext_fault;

    logic [7:0]  rom_mem [65536];
    logic [16:0] ea_limit;
    logic [15:0] rom_a1;
    logic [15:0] rom_a2;

    int n_checks;
    int n_pass;

    int unsigned len_map [16][16];

    typedef struct packed {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
        logic [1:0] elen;
    } vec_t;

    vec_t vecs [12];

    oc8051_fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data1  (rom_data1),
        .rom_data2  (rom_data2),
        .rom_data3  (rom_data3),
        .rom_ea_int (rom_ea_int),
        .jmp_valid  (jmp_valid),
        .jmp_addr   (jmp_addr),
        .dec_ready  (dec_ready),
        .dec_valid  (dec_valid),
        .dec_op1    (dec_op1),
        .dec_op2    (dec_op2),
        .dec_op3    (dec_op3),
        .dec_pc     (dec_pc),
        .dec_len    (dec_len),
        .ext_fault  (ext_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous three-byte ROM window, wrapping at 64K.
    assign rom_a1     = rom_addr + 16'd1;
    assign rom_a2     = rom_addr + 16'd2;
    assign rom_ea_int = ({1'b0, rom_addr} < ea_limit);

    always @(posedge clk) begin
        rom_data1 <= rom_mem[rom_addr];
        rom_data2 <= rom_mem[rom_a1];
        rom_data3 <= rom_mem[rom_a2];
    end

    function automatic int unsigned ref_len(input logic [7:0] op);
        return len_map[op[7:4]][op[3:0]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [15:0] a, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3);
        rom_mem[a]         = b1;
        rom_mem[a + 16'd1] = b2;
        rom_mem[a + 16'd2] = b3;
    endtask

    task automatic expect_instr(input string tag, input logic [15:0] pc, input logic [7:0] o1,
                                input logic [7:0] o2, input logic [7:0] o3,
                                input logic [1:0] len);
        check({tag, ".valid"}, {31'd0, dec_valid}, 32'd1);
        check({tag, ".pc"}, {16'd0, dec_pc}, {16'd0, pc});
        check({tag, ".op1"}, {24'd0, dec_op1}, {24'd0, o1});
        check({tag, ".op2"}, {24'd0, dec_op2}, {24'd0, o2});
        check({tag, ".op3"}, {24'd0, dec_op3}, {24'd0, o3});
        check({tag, ".len"}, {30'd0, dec_len}, {30'd0, len});
    endtask

    task automatic do_jump(input logic [15:0] target);
        jmp_valid = 1'b1;
        jmp_addr  = target;
        tick();
        jmp_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] m_pc;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] exp_addr;
        logic [7:0]  e2;
        logic [7:0]  e3;
        int unsigned l;
        int          since;
        bit          exp_valid;
        bit          exp_fault;

        n_checks = 0;
        n_pass   = 0;
        len_map = '{
            '{1,2,3,1,1,2,1,1,1,1,1,1,1,1,1,1},
            '{3,2,3,1,1,2,1,1,1,1,1,1,1,1,1,1},
            '{3,2,1,1,2,2,1,1,1,1,1,1,1,1,1,1},
            '{3,2,1,1,2,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,3,2,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,3,2,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,3,2,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,1,2,3,2,2,2,2,2,2,2,2,2,2},
            '{2,2,2,1,1,3,2,2,2,2,2,2,2,2,2,2},
            '{3,2,2,1,2,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,1,1,1,2,2,2,2,2,2,2,2,2,2},
            '{2,2,2,1,3,3,3,3,3,3,3,3,3,3,3,3},
            '{2,2,2,1,1,2,1,1,1,1,1,1,1,1,1,1},
            '{2,2,2,1,1,3,1,1,2,2,2,2,2,2,2,2},
            '{1,2,1,1,1,2,1,1,1,1,1,1,1,1,1,1},
            '{1,2,1,1,1,2,1,1,1,1,1,1,1,1,1,1}
        };
        vecs[0]  = '{8'h85, 8'hD0, 8'h90, 8'h85, 8'hD0, 8'h90, 2'd3};
        vecs[1]  = '{8'hE4, 8'hF8, 8'h7C, 8'hE4, 8'h00, 8'h00, 2'd1};
        vecs[2]  = '{8'h74, 8'h12, 8'h34, 8'h74, 8'h12, 8'h00, 2'd2};
        vecs[3]  = '{8'hA5, 8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 2'd1};
        vecs[4]  = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h00, 2'd2};
        vecs[5]  = '{8'hD8, 8'hFE, 8'h77, 8'hD8, 8'hFE, 8'h00, 2'd2};
        vecs[6]  = '{8'hB6, 8'h01, 8'h02, 8'hB6, 8'h01, 8'h02, 2'd3};
        vecs[7]  = '{8'h02, 8'h12, 8'h34, 8'h02, 8'h12, 8'h34, 2'd3};
        vecs[8]  = '{8'h22, 8'h55, 8'h66, 8'h22, 8'h00, 8'h00, 2'd1};
        vecs[9]  = '{8'hD6, 8'h44, 8'h55, 8'hD6, 8'h00, 8'h00, 2'd1};
        vecs[10] = '{8'h43, 8'h80, 8'h01, 8'h43, 8'h80, 8'h01, 2'd3};
        vecs[11] = '{8'h93, 8'h01, 8'h02, 8'h93, 8'h00, 8'h00, 2'd1};

        for (int i = 0; i < 65536; i++) begin
            rom_mem[i] = 8'($urandom);
        end
        load3(16'h0000, 8'h85, 8'hD0, 8'h90);
        load3(16'h0003, 8'h02, 8'h00, 8'h20);
        rom_mem[16'h0006] = 8'h00;
        load3(16'h0007, 8'hE4, 8'hF8, 8'h7C);
        rom_mem[16'h000A] = 8'h5A;
        load3(16'h000B, 8'h75, 8'hD0, 8'h08);
        rom_mem[16'h000E] = 8'h00;
        rom_mem[16'h0026] = 8'hE8;
        rom_mem[16'h007E] = 8'h00;
        rom_mem[16'h007F] = 8'h00;

        rst       = 1'b0;
        jmp_valid = 1'b0;
        jmp_addr  = 16'h0000;
        dec_ready = 1'b0;
        ea_limit  = 17'h00080;
        tick();
        tick();
        check("rst.valid", {31'd0, dec_valid}, 32'd0);
        check("rst.fault", {31'd0, ext_fault}, 32'd0);
        check("rst.op1", {24'd0, dec_op1}, 32'd0);
        check("rst.pc", {16'd0, dec_pc}, 32'd0);
        check("rst.len", {30'd0, dec_len}, 32'd0);
        check("rst.rom_addr", {16'd0, rom_addr}, 32'h0000);

        // Straight-line fetch from the reset vector, two cycles per instruction.
        rst       = 1'b1;
        dec_ready = 1'b1;
        tick();
        check("t1.lat1.valid", {31'd0, dec_valid}, 32'd0);
        tick();
        expect_instr("t1.i0", 16'h0000, 8'h85, 8'hD0, 8'h90, 2'd3);
        check("t1.next_addr", {16'd0, rom_addr}, 32'h0003);
        tick(); tick();
        expect_instr("t1.i3", 16'h0003, 8'h02, 8'h00, 8'h20, 2'd3);
        tick(); tick();
        expect_instr("t1.i6", 16'h0006, 8'h00, 8'h00, 8'h00, 2'd1);
        tick(); tick();
        expect_instr("t2.i7", 16'h0007, 8'hE4, 8'h00, 8'h00, 2'd1);
        check("t2.next_addr", {16'd0, rom_addr}, 32'h0008);
        tick(); tick();
        expect_instr("t2.i8", 16'h0008, 8'hF8, 8'h00, 8'h00, 2'd1);
        tick(); tick();
        expect_instr("t2.i9", 16'h0009, 8'h7C, 8'h5A, 8'h00, 2'd2);

        // Back-pressure holds the presented instruction and the fetch address.
        tick();
        dec_ready = 1'b0;
        tick();
        expect_instr("t3.iB", 16'h000B, 8'h75, 8'hD0, 8'h08, 2'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3.hold.valid", {31'd0, dec_valid}, 32'd1);
            check("t3.hold.pc", {16'd0, dec_pc}, 32'h000B);
            check("t3.hold.op1", {24'd0, dec_op1}, 32'h75);
            check("t3.hold.rom_addr", {16'd0, rom_addr}, 32'h000B);
        end
        dec_ready = 1'b1;
        #1;
        check("t3.accept_addr", {16'd0, rom_addr}, 32'h000E);
        tick(); tick();
        expect_instr("t3.iE", 16'h000E, 8'h00, 8'h00, 8'h00, 2'd1);

        // Jump in the same cycle as an accept: the jump wins.
        jmp_valid = 1'b1;
        jmp_addr  = 16'h0026;
        #1;
        check("t4.rom_addr", {16'd0, rom_addr}, 32'h0026);
        tick();
        jmp_valid = 1'b0;
        check("t4.killed", {31'd0, dec_valid}, 32'd0);
        tick();
        expect_instr("t4.i26", 16'h0026, 8'hE8, 8'h00, 8'h00, 2'd1);

        // Running off the end of internal ROM.
        do_jump(16'h007E);
        tick();
        expect_instr("t5.i7E", 16'h007E, 8'h00, 8'h00, 8'h00, 2'd1);
        tick(); tick();
        expect_instr("t5.i7F", 16'h007F, 8'h00, 8'h00, 8'h00, 2'd1);
        tick();
        check("t5.data.fault", {31'd0, ext_fault}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t5.fault", {31'd0, ext_fault}, 32'd1);
            check("t5.fault.valid", {31'd0, dec_valid}, 32'd0);
            check("t5.fault.rom_addr", {16'd0, rom_addr}, 32'h0080);
            tick();
        end
        jmp_valid = 1'b1;
        jmp_addr  = 16'h0000;
        #1;
        check("t5.jmp.rom_addr", {16'd0, rom_addr}, 32'h0000);
        tick();
        jmp_valid = 1'b0;
        check("t5.cleared", {31'd0, ext_fault}, 32'd0);
        tick();
        expect_instr("t5.i0", 16'h0000, 8'h85, 8'hD0, 8'h90, 2'd3);

        // Asynchronous reset while an instruction is presented.
        dec_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("t6.valid", {31'd0, dec_valid}, 32'd0);
        check("t6.fault", {31'd0, ext_fault}, 32'd0);
        check("t6.op1", {24'd0, dec_op1}, 32'd0);
        check("t6.op2", {24'd0, dec_op2}, 32'd0);
        check("t6.op3", {24'd0, dec_op3}, 32'd0);
        check("t6.pc", {16'd0, dec_pc}, 32'd0);
        check("t6.len", {30'd0, dec_len}, 32'd0);
        tick();
        rst       = 1'b1;
        dec_ready = 1'b1;
        tick();
        check("t6.lat1.valid", {31'd0, dec_valid}, 32'd0);
        tick();
        expect_instr("t6.i0", 16'h0000, 8'h85, 8'hD0, 8'h90, 2'd3);

        // 16-bit PC wrap.
        ea_limit = 17'h10000;
        rom_mem[16'hFFFF] = 8'h00;
        do_jump(16'hFFFF);
        tick();
        expect_instr("wrap.iFFFF", 16'hFFFF, 8'h00, 8'h00, 8'h00, 2'd1);
        check("wrap.rom_addr", {16'd0, rom_addr}, 32'h0000);
        tick(); tick();
        check("wrap.pc", {16'd0, dec_pc}, 32'h0000);

        // Opcode vector table, each reached by a jump with the decoder stalled.
        dec_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [15:0] base;
            base = 16'h0200 + 16'(i * 4);
            load3(base, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            do_jump(base);
            tick();
            expect_instr($sformatf("vec%0d", i), base, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                         vecs[i].elen);
        end

        // Random run against the fetch-stream model.
        rst       = 1'b0;
        ea_limit  = 17'h0C000;
        tick();
        @(negedge clk);
        rst   = 1'b1;
        m_pc  = 16'h0000;
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            jmp_valid = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 9);
            if (r < 8) begin
                jmp_addr = 16'($urandom_range(0, 16'hBFFF));
            end else if (r == 8) begin
                jmp_addr = 16'($urandom_range(16'hC000, 16'hFFFF));
            end else begin
                jmp_addr = 16'($urandom_range(16'hBFF0, 16'hBFFF));
            end
            dec_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_valid = (since >= 2) && ({1'b0, m_pc} < ea_limit);
            exp_fault = (since >= 2) && !({1'b0, m_pc} < ea_limit);
            l         = ref_len(rom_mem[m_pc]);
            if (jmp_valid) begin
                exp_addr = jmp_addr;
            end else if (exp_valid && dec_ready) begin
                exp_addr = m_pc + 16'(l);
            end else begin
                exp_addr = m_pc;
            end
            check("rnd.valid", {31'd0, dec_valid}, {31'd0, exp_valid});
            check("rnd.fault", {31'd0, ext_fault}, {31'd0, exp_fault});
            check("rnd.rom_addr", {16'd0, rom_addr}, {16'd0, exp_addr});
            if (exp_valid) begin
                a1 = m_pc + 16'd1;
                a2 = m_pc + 16'd2;
                e2 = (l >= 2) ? rom_mem[a1] : 8'h00;
                e3 = (l == 3) ? rom_mem[a2] : 8'h00;
                expect_instr("rnd", m_pc, rom_mem[m_pc], e2, e3, 2'(l));
            end
            @(posedge clk);
            if (jmp_valid) begin
                m_pc  = jmp_addr;
                since = 1;
            end else if (exp_valid && dec_ready) begin
                m_pc  = m_pc + 16'(l);
                since = 1;
            end else if (since < 2) begin
                since++;
            end
            @(negedge clk);
        end
        jmp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
